// File: rtl/ptw_axi_reader_pkg.sv
// rtl/ptw_axi_reader_pkg.sv - shared types and AXI constants for the PTE reader
// Purpose: state encoding, AXI burst/resp/prot constants, PTE width and the
//          ARSIZE helper used by ptw_axi_reader.
// Ports:   none (package).
package ptw_axi_reader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ADDR  = 2'd1,
      ST_DATA  = 2'd2,
      ST_DRAIN = 2'd3
   } ptw_state_t;

   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   // Privileged, secure, data access.
   localparam logic [2:0] AXI_PROT_PTW = 3'b001;

   localparam int PTE_WIDTH = 64;

   // ARSIZE encoding for a single beat of data_width bits.
   function automatic logic [2:0] axi_size(input int data_width);
      return 3'($clog2(data_width / 8));
   endfunction

endpackage

// File: rtl/ptw_axi_reader.sv
// rtl/ptw_axi_reader.sv - single-outstanding AXI4 reader for page-table entries
// Purpose: turns a one-cycle PTE read request from the TLB walker into one
//          single-beat AXI4 read, returns the entry (or an access fault) as a
//          one-cycle response, supports abort and an R-channel timeout.
// Ports:   i_clk/i_rstn          clock, synchronous active-low reset
//          i_req_valid/i_req_addr request pulse and PTE physical address
//          i_abort               flush/cancel of the outstanding read
//          o_resp_valid/_data/_err response pulse, PTE, fault flag
//          o_busy                high whenever not idle
//          o_m_axi_ar*/i_m_axi_arready  AXI4 read-address channel
//          i_m_axi_r*/o_m_axi_rready    AXI4 read-data channel
module ptw_axi_reader
   import ptw_axi_reader_pkg::*;
#(
   parameter int ADDR_WIDTH     = 64,
   parameter int DATA_WIDTH     = PTE_WIDTH,
   parameter int ID_WIDTH       = 4,
   parameter int AXI_ID         = 0,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  i_clk,
   input  logic                  i_rstn,
   input  logic                  i_req_valid,
   input  logic [ADDR_WIDTH-1:0] i_req_addr,
   input  logic                  i_abort,
   output logic                  o_resp_valid,
   output logic [DATA_WIDTH-1:0] o_resp_data,
   output logic                  o_resp_err,
   output logic                  o_busy,
   output logic                  o_m_axi_arvalid,
   input  logic                  i_m_axi_arready,
   output logic [ADDR_WIDTH-1:0] o_m_axi_araddr,
   output logic [ID_WIDTH-1:0]   o_m_axi_arid,
   output logic [7:0]            o_m_axi_arlen,
   output logic [2:0]            o_m_axi_arsize,
   output logic [1:0]            o_m_axi_arburst,
   output logic [2:0]            o_m_axi_arprot,
   input  logic                  i_m_axi_rvalid,
   output logic                  o_m_axi_rready,
   input  logic [DATA_WIDTH-1:0] i_m_axi_rdata,
   input  logic [1:0]            i_m_axi_rresp,
   input  logic                  i_m_axi_rlast,
   input  logic [ID_WIDTH-1:0]   i_m_axi_rid
);

   localparam int             CW      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [ID_WIDTH-1:0] W_ID = ID_WIDTH'(AXI_ID);

   ptw_state_t            r_state, w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_araddr;
   logic                  r_abort_seen, w_abort_seen_nxt;
   logic [CW-1:0]         r_cnt, w_cnt_nxt;
   logic                  r_resp_valid, r_resp_err;
   logic [DATA_WIDTH-1:0] r_resp_data;

   logic                  w_latch_addr;
   logic                  w_resp_fire;
   logic                  w_resp_err_nxt;
   logic [DATA_WIDTH-1:0] w_resp_data_nxt;
   logic                  w_beat_err;
   logic [ADDR_WIDTH-1:0] w_req_addr_aligned;

   // PTEs are 8-byte aligned; low address bits are ignored.
   assign w_req_addr_aligned = i_req_addr & ~ADDR_WIDTH'(3'b111);

   // A beat is faulty on SLVERR/DECERR, a foreign ID, or a non-final beat.
   assign w_beat_err = (i_m_axi_rresp == AXI_RESP_SLVERR) ||
                       (i_m_axi_rresp == AXI_RESP_DECERR) ||
                       (i_m_axi_rid != W_ID) || !i_m_axi_rlast;

   always_comb begin
      w_state_nxt      = r_state;
      w_abort_seen_nxt = r_abort_seen;
      w_cnt_nxt        = r_cnt;
      w_latch_addr     = 1'b0;
      w_resp_fire      = 1'b0;
      w_resp_err_nxt   = 1'b0;
      w_resp_data_nxt  = '0;
      case (r_state)
         ST_IDLE: begin
            w_abort_seen_nxt = 1'b0;
            if (i_req_valid) begin
               w_latch_addr = 1'b1;
               w_state_nxt  = ST_ADDR;
            end
         end
         ST_ADDR: begin
            // ARVALID must stay up until accepted, so an abort is only
            // remembered here and acted on after the handshake.
            if (i_abort) w_abort_seen_nxt = 1'b1;
            if (i_m_axi_arready) begin
               w_cnt_nxt        = '0;
               w_abort_seen_nxt = 1'b0;
               w_state_nxt      = (i_abort || r_abort_seen) ? ST_DRAIN : ST_DATA;
            end
         end
         ST_DATA: begin
            if (i_m_axi_rvalid) begin
               w_state_nxt = ST_IDLE;
               if (!i_abort) begin
                  w_resp_fire     = 1'b1;
                  w_resp_data_nxt = i_m_axi_rdata;
                  w_resp_err_nxt  = w_beat_err;
               end
            end else if (i_abort) begin
               w_state_nxt = ST_DRAIN;
            end else if (r_cnt == TO_LAST) begin
               // Report the fault now but still swallow the late beat.
               w_resp_fire    = 1'b1;
               w_resp_err_nxt = 1'b1;
               w_state_nxt    = ST_DRAIN;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         ST_DRAIN: begin
            if (i_m_axi_rvalid) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_state      <= ST_IDLE;
         r_araddr     <= '0;
         r_abort_seen <= 1'b0;
         r_cnt        <= '0;
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         r_resp_data  <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_abort_seen <= w_abort_seen_nxt;
         r_cnt        <= w_cnt_nxt;
         r_resp_valid <= w_resp_fire;
         if (w_latch_addr) r_araddr <= w_req_addr_aligned;
         if (w_resp_fire) begin
            r_resp_err  <= w_resp_err_nxt;
            r_resp_data <= w_resp_data_nxt;
         end
      end
   end

   assign o_busy          = (r_state != ST_IDLE);
   assign o_m_axi_arvalid = (r_state == ST_ADDR);
   assign o_m_axi_rready  = (r_state == ST_DATA) || (r_state == ST_DRAIN);
   assign o_m_axi_araddr  = r_araddr;
   assign o_m_axi_arid    = W_ID;
   assign o_m_axi_arlen   = 8'd0;
   assign o_m_axi_arsize  = axi_size(DATA_WIDTH);
   assign o_m_axi_arburst = AXI_BURST_INCR;
   assign o_m_axi_arprot  = AXI_PROT_PTW;
   assign o_resp_valid    = r_resp_valid;
   assign o_resp_err      = r_resp_err;
   assign o_resp_data     = r_resp_data;

endmodule

// File: tb/tb_ptw_axi_reader.sv
// tb/tb_ptw_axi_reader.sv - self-checking bench for ptw_axi_reader
module tb_ptw_axi_reader;

   localparam int         AW = 64;
   localparam int         DW = 64;
   localparam int         IW = 4;
   localparam logic [3:0] ID = 4'h5;
   localparam int         TO = 8;

   logic          clk = 1'b0;
   logic          rstn;
   logic          req_valid;
   logic [AW-1:0] req_addr;
   logic          abort;
   logic          resp_valid;
   logic [DW-1:0] resp_data;
   logic          resp_err;
   logic          busy;
   logic          arvalid;
   logic          arready;
   logic [AW-1:0] araddr;
   logic [IW-1:0] arid;
   logic [7:0]    arlen;
   logic [2:0]    arsize;
   logic [1:0]    arburst;
   logic [2:0]    arprot;
   logic          rvalid;
   logic          rready;
   logic [DW-1:0] rdata;
   logic [1:0]    rresp;
   logic          rlast;
   logic [IW-1:0] rid;

   ptw_axi_reader #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW),
      .AXI_ID(int'(ID)), .TIMEOUT_CYCLES(TO)
   ) dut (
      .i_clk(clk), .i_rstn(rstn), .i_req_valid(req_valid), .i_req_addr(req_addr),
      .i_abort(abort), .o_resp_valid(resp_valid), .o_resp_data(resp_data),
      .o_resp_err(resp_err), .o_busy(busy),
      .o_m_axi_arvalid(arvalid), .i_m_axi_arready(arready), .o_m_axi_araddr(araddr),
      .o_m_axi_arid(arid), .o_m_axi_arlen(arlen), .o_m_axi_arsize(arsize),
      .o_m_axi_arburst(arburst), .o_m_axi_arprot(arprot),
      .i_m_axi_rvalid(rvalid), .o_m_axi_rready(rready), .i_m_axi_rdata(rdata),
      .i_m_axi_rresp(rresp), .i_m_axi_rlast(rlast), .i_m_axi_rid(rid)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int ar_hs = 0;
   int resp_cnt = 0;

   always @(posedge clk) begin
      if (rstn && arvalid && arready) ar_hs++;
      if (resp_valid) resp_cnt++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Reference rules: 8-byte aligned address; fault on SLVERR/DECERR,
   // wrong ID or missing RLAST.
   function automatic logic [63:0] model_addr(input logic [63:0] a);
      return a - (a % 64'd8);
   endfunction

   function automatic logic model_err(input logic [1:0] rr, input logic [3:0] id, input logic last);
      return (rr >= 2'd2) || (id != ID) || !last;
   endfunction

   task automatic issue_req(input logic [63:0] addr);
      req_valid = 1'b1;
      req_addr  = addr;
      tick;
      req_valid = 1'b0;
      req_addr  = {$urandom, $urandom};
   endtask

   task automatic accept_ar;
      arready = 1'b1;
      tick;
      arready = 1'b0;
   endtask

   task automatic run_txn(input logic [63:0] addr, input int ar_dly, input int r_dly,
                          input logic [63:0] data, input logic [1:0] rr,
                          input logic [3:0] id, input logic last, input bit extra_req);
      int hs0;
      logic [63:0] exp_a;
      hs0   = ar_hs;
      exp_a = model_addr(addr);
      issue_req(addr);
      chk("arvalid_up", arvalid, 1);
      chk("araddr", araddr, exp_a);
      for (int k = 0; k < ar_dly; k++) begin
         if (extra_req && k == 1) begin
            req_valid = 1'b1;
            req_addr  = ~addr;
         end
         tick;
         req_valid = 1'b0;
         chk("ar_hold_valid", arvalid, 1);
         chk("ar_hold_addr", araddr, exp_a);
      end
      accept_ar;
      chk("ar_hs_once", 64'(ar_hs - hs0), 1);
      chk("rready_data", rready, 1);
      chk("arvalid_down", arvalid, 0);
      for (int k = 0; k < r_dly; k++) begin
         tick;
         chk("no_early_resp", resp_valid, 0);
      end
      rvalid = 1'b1; rdata = data; rresp = rr; rid = id; rlast = last;
      tick;
      rvalid = 1'b0;
      chk("resp_valid", resp_valid, 1);
      chk("resp_data", resp_data, data);
      chk("resp_err", resp_err, model_err(rr, id, last));
      chk("busy_after", busy, 0);
      tick;
      chk("resp_pulse_end", resp_valid, 0);
      chk("ar_hs_total", 64'(ar_hs - hs0), 1);
   endtask

   initial begin
      int rc0;
      logic [63:0] a, d;
      logic [1:0]  rr;
      logic [3:0]  id;
      logic        last;

      rstn = 1'b0; req_valid = 1'b0; req_addr = '0; abort = 1'b0;
      arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b1; rid = ID;
      tick; tick;
      chk("rst_arvalid", arvalid, 0);
      chk("rst_rready", rready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_err", resp_err, 0);
      chk("rst_resp_data", resp_data, 0);
      chk("rst_araddr", araddr, 0);
      chk("rst_busy", busy, 0);
      chk("arlen", arlen, 0);
      chk("arsize", arsize, $clog2(DW / 8));
      chk("arburst", arburst, 2'b01);
      chk("arprot", arprot, 3'b001);
      chk("arid", arid, ID);
      rstn = 1'b1;
      tick;

      // Basic read with ARREADY high.
      run_txn(64'h8000_1234, 0, 0, 64'h2000_00CF, 2'b00, ID, 1'b1, 1'b0);
      // ARREADY stalled 5 cycles with a dropped second request.
      run_txn(64'h0000_0040_1000_0ABF, 5, 1, 64'h1234_5678_9ABC_DEF0, 2'b00, ID, 1'b1, 1'b1);
      // SLVERR.
      run_txn(64'h8000_2008, 0, 2, 64'hDEAD_BEEF, 2'b10, ID, 1'b1, 1'b0);

      // Randomized transactions.
      for (int i = 0; i < 8; i++) begin
         a    = {$urandom, $urandom};
         d    = {$urandom, $urandom};
         rr   = 2'($urandom_range(0, 3));
         id   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : ID;
         last = ($urandom_range(0, 4) != 0);
         run_txn(a, $urandom_range(0, 3), $urandom_range(0, 5), d, rr, id, last, 1'b0);
      end

      // Abort in IDLE: no effect.
      abort = 1'b1; tick; abort = 1'b0;
      chk("idle_abort_busy", busy, 0);
      chk("idle_abort_arvalid", arvalid, 0);

      // Abort two cycles after AR handshake, R three cycles later.
      rc0 = resp_cnt;
      issue_req(64'h8000_3000);
      accept_ar;
      tick;
      abort = 1'b1; tick; abort = 1'b0;
      chk("drain_rready", rready, 1);
      chk("drain_busy", busy, 1);
      tick; tick;
      rvalid = 1'b1; rdata = 64'hAAAA; rresp = 2'b00; rid = ID; rlast = 1'b1;
      tick; rvalid = 1'b0;
      chk("drain_idle", busy, 0);
      tick;
      chk("drain_no_resp", 64'(resp_cnt - rc0), 0);

      // Abort and R handshake in the same cycle.
      rc0 = resp_cnt;
      issue_req(64'h8000_4000);
      accept_ar;
      abort = 1'b1; rvalid = 1'b1; rdata = 64'hBBBB;
      tick; abort = 1'b0; rvalid = 1'b0;
      chk("abort_r_idle", busy, 0);
      tick;
      chk("abort_r_no_resp", 64'(resp_cnt - rc0), 0);

      // Abort while AR is stalled: ARVALID holds, then drain one beat.
      rc0 = resp_cnt;
      issue_req(64'h8000_5000);
      abort = 1'b1; tick; abort = 1'b0;
      chk("addr_abort_arvalid", arvalid, 1);
      accept_ar;
      chk("addr_abort_drain", rready, 1);
      rvalid = 1'b1; tick; rvalid = 1'b0;
      chk("addr_abort_idle", busy, 0);
      tick;
      chk("addr_abort_no_resp", 64'(resp_cnt - rc0), 0);

      // Timeout: no RVALID for TO DATA cycles.
      issue_req(64'h8000_6000);
      accept_ar;
      for (int k = 0; k < TO - 1; k++) begin
         tick;
         chk("to_quiet", resp_valid, 0);
      end
      tick;
      chk("to_resp_valid", resp_valid, 1);
      chk("to_resp_err", resp_err, 1);
      chk("to_resp_data", resp_data, 0);
      chk("to_drain_busy", busy, 1);
      tick;
      chk("to_pulse_end", resp_valid, 0);
      chk("to_drain_rready", rready, 1);
      rc0 = resp_cnt;
      rvalid = 1'b1; rdata = 64'hCCCC; tick; rvalid = 1'b0;
      chk("to_late_idle", busy, 0);
      tick;
      chk("to_late_no_resp", 64'(resp_cnt - rc0), 0);

      // Leave a non-zero response behind, then reset during DATA.
      run_txn(64'h8000_7010, 0, 0, 64'hFACE_0001, 2'b11, ID, 1'b1, 1'b0);
      issue_req(64'h8000_8000);
      accept_ar;
      rstn = 1'b0; tick; rstn = 1'b1;
      chk("mrst_arvalid", arvalid, 0);
      chk("mrst_rready", rready, 0);
      chk("mrst_resp_valid", resp_valid, 0);
      chk("mrst_resp_err", resp_err, 0);
      chk("mrst_resp_data", resp_data, 0);
      chk("mrst_araddr", araddr, 0);
      chk("mrst_busy", busy, 0);
      run_txn(64'h8000_9018, 1, 1, 64'h0123_4567, 2'b00, ID, 1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
